demux1_to_n_reg: RTL and testbench

//  Registered 1-to-N demultiplexer with a per-channel valid/ack handshake.
//  It is the receive end of the 2:1 / N:1 selector path: a shared data

---
 rtl/demux1_to_n_reg.sv | 88 ++++++++
 tb/tb_demux1_to_n_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_to_n_reg.sv
// Registered 1-to-N demultiplexer: steers a shared beat stream into N holding
// registers by explicit select or internal round-robin scan, with per-channel valid/ack.
module demux1_to_n_reg #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned N     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic                   auto,
    input  logic                   sync_clr,
    output logic [N*WIDTH-1:0]     Q,
    output logic [N-1:0]           out_valid,
    input  logic [N-1:0]           out_ack,
    output logic                   err
);

    localparam int unsigned SELW = $clog2(N);
    localparam int unsigned NP   = 1 << SELW;
    localparam logic [SELW:0]   N_W  = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [N*WIDTH-1:0] q_q, q_d;
    logic [N-1:0]       valid_q, valid_d;
    logic [SELW-1:0]    ptr_q, ptr_d;
    logic               err_q, err_d;

    logic [SELW-1:0]    ch_c;
    logic               in_range_c;
    logic               accept_c;
    logic [NP-1:0]      valid_pad_c;
    logic [NP-1:0]      ack_pad_c;

    // Flags padded to a power of two so a select beyond N-1 still indexes safely
    assign ch_c        = auto ? ptr_q : sel;
    assign in_range_c  = {1'b0, ch_c} < N_W;
    assign valid_pad_c = NP'(valid_q);
    assign ack_pad_c   = NP'(out_ack);
    assign in_ready    = ~in_range_c | ~valid_pad_c[ch_c] | ack_pad_c[ch_c];
    assign accept_c    = in_valid & in_ready;

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        err_d   = 1'b0;
        // An ack releases a slot; a same-cycle accept into that slot re-fills it
        for (int unsigned k = 0; k < N; k++) begin
            if (out_ack[k]) begin
                valid_d[k] = 1'b0;
            end
            if (accept_c && in_range_c && (ch_c == SELW'(k))) begin
                q_d[k*WIDTH +: WIDTH] = din;
                valid_d[k]            = 1'b1;
            end
        end
        if (accept_c && !in_range_c) begin
            err_d = 1'b1;
        end
        if (sync_clr) begin
            ptr_d = '0;
        end else if (accept_c && auto) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + SELW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign Q         = q_q;
    assign out_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_demux1_to_n_reg.sv
// Directed bench for demux1_to_n_reg: three instances (N=2/W=1, N=4/W=8, N=3/W=4)
// exercised by one task per scenario with hand-computed expectations.
module tb_demux1_to_n_reg;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Instance a: N=2, WIDTH=1
    logic       din_a, in_valid_a, in_ready_a, sel_a, auto_a, clr_a, err_a;
    logic [1:0] q_a, valid_a, ack_a;
    // Instance b: N=4, WIDTH=8
    logic [7:0]  din_b;
    logic        in_valid_b, in_ready_b, auto_b, clr_b, err_b;
    logic [1:0]  sel_b;
    logic [31:0] q_b;
    logic [3:0]  valid_b, ack_b;
    // Instance c: N=3, WIDTH=4
    logic [3:0]  din_c;
    logic        in_valid_c, in_ready_c, auto_c, clr_c, err_c;
    logic [1:0]  sel_c;
    logic [11:0] q_c;
    logic [2:0]  valid_c, ack_c;

    demux1_to_n_reg #(.WIDTH(1), .N(2)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .sel(sel_a), .auto(auto_a), .sync_clr(clr_a), .Q(q_a), .out_valid(valid_a),
        .out_ack(ack_a), .err(err_a)
    );

    demux1_to_n_reg #(.WIDTH(8), .N(4)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .sel(sel_b), .auto(auto_b), .sync_clr(clr_b), .Q(q_b), .out_valid(valid_b),
        .out_ack(ack_b), .err(err_b)
    );

    demux1_to_n_reg #(.WIDTH(4), .N(3)) u_c (
        .clk(clk), .rst(rst), .din(din_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .sel(sel_c), .auto(auto_c), .sync_clr(clr_c), .Q(q_c), .out_valid(valid_c),
        .out_ack(ack_c), .err(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_all;
        in_valid_a = 0; ack_a = '0; clr_a = 0; auto_a = 0;
        in_valid_b = 0; ack_b = '0; clr_b = 0; auto_b = 0;
        in_valid_c = 0; ack_c = '0; clr_c = 0; auto_c = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++; if (q_a !== 2'b00)       begin bad++; $display("FAIL reset_q_a: got %b exp 00", q_a); end
        total++; if (valid_a !== 2'b00)   begin bad++; $display("FAIL reset_valid_a: got %b exp 00", valid_a); end
        total++; if (err_a !== 1'b0)      begin bad++; $display("FAIL reset_err_a: got %b exp 0", err_a); end
        total++; if (q_b !== 32'h0)       begin bad++; $display("FAIL reset_q_b: got %h exp 0", q_b); end
        total++; if (valid_c !== 3'b000)  begin bad++; $display("FAIL reset_valid_c: got %b exp 000", valid_c); end
        rst = 1'b0;
        #1;
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready_a: got %b exp 1", in_ready_a); end
        total++; if (in_ready_b !== 1'b1) begin bad++; $display("FAIL reset_ready_b: got %b exp 1", in_ready_b); end
    endtask

    task automatic test_select_n2;
        logic [1:0] eq;
        logic [1:0] ev;
        do_reset();
        eq = 2'b00;
        ev = 2'b00;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 2; d++) begin
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    din_a = d[0]; sel_a = s[0]; in_valid_a = 1; ack_a = 2'b11;
                    #1;
                    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL sel_ready d=%0d s=%0d: got %b exp 1", d, s, in_ready_a); end
                    @(posedge clk); #1;
                    eq[s] = d[0];
                    ev    = 2'b00;
                    ev[s] = 1'b1;
                    total++; if (q_a !== eq)     begin bad++; $display("FAIL sel_q d=%0d s=%0d: got %b exp %b", d, s, q_a, eq); end
                    total++; if (valid_a !== ev) begin bad++; $display("FAIL sel_valid d=%0d s=%0d: got %b exp %b", d, s, valid_a, ev); end
                end
            end
        end
        @(negedge clk); idle_all();
    endtask

    task automatic test_backpressure;
        do_reset();
        @(negedge clk);
        din_a = 0; sel_a = 0; in_valid_a = 1; ack_a = 2'b00;
        @(posedge clk); #1;
        total++; if (valid_a !== 2'b01) begin bad++; $display("FAIL bp_fill_valid: got %b exp 01", valid_a); end
        @(negedge clk);
        din_a = 1; sel_a = 0; in_valid_a = 1; ack_a = 2'b00;
        #1;
        total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b exp 0", in_ready_a); end
        @(posedge clk); #1;
        total++; if (q_a !== 2'b00)     begin bad++; $display("FAIL bp_q_hold: got %b exp 00", q_a); end
        total++; if (valid_a !== 2'b01) begin bad++; $display("FAIL bp_valid_hold: got %b exp 01", valid_a); end
        @(negedge clk);
        ack_a = 2'b01;
        #1;
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL bp_ready_ack: got %b exp 1", in_ready_a); end
        @(posedge clk); #1;
        total++; if (q_a !== 2'b01)     begin bad++; $display("FAIL bp_q_ack: got %b exp 01", q_a); end
        total++; if (valid_a !== 2'b01) begin bad++; $display("FAIL bp_valid_ack: got %b exp 01", valid_a); end
        @(negedge clk); in_valid_a = 0; ack_a = 2'b00;
    endtask

    task automatic test_ack;
        // Continues from q=01, valid=01
        @(negedge clk);
        in_valid_a = 0; ack_a = 2'b01;
        @(posedge clk); #1;
        total++; if (valid_a !== 2'b00) begin bad++; $display("FAIL ack_clear_valid: got %b exp 00", valid_a); end
        total++; if (q_a !== 2'b01)     begin bad++; $display("FAIL ack_q_hold: got %b exp 01", q_a); end
        @(negedge clk);
        din_a = 1; sel_a = 1; in_valid_a = 1; ack_a = 2'b01;
        @(posedge clk); #1;
        total++; if (valid_a !== 2'b10) begin bad++; $display("FAIL ack_ignored_valid: got %b exp 10", valid_a); end
        total++; if (q_a !== 2'b11)     begin bad++; $display("FAIL ack_ignored_q: got %b exp 11", q_a); end
        @(negedge clk); idle_all();
    endtask

    task automatic test_auto_scan;
        int k;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            auto_b = 1; sel_b = 2'd3; din_b = 8'(i); in_valid_b = 1; ack_b = 4'b1111;
            @(posedge clk); #1;
            k = (i - 1) % 4;
            total++; if (q_b[8*k +: 8] !== 8'(i)) begin bad++; $display("FAIL scan_slice beat=%0d: got %0d exp %0d", i, q_b[8*k +: 8], i); end
            total++; if (valid_b !== 4'(1 << k))  begin bad++; $display("FAIL scan_valid beat=%0d: got %b exp %b", i, valid_b, 4'(1 << k)); end
        end
        total++; if (q_b !== 32'h04030205) begin bad++; $display("FAIL scan_final_q: got %h exp 04030205", q_b); end
        @(negedge clk); idle_all();
    endtask

    task automatic test_sync_clr;
        do_reset();
        for (int i = 7; i <= 8; i++) begin
            @(negedge clk);
            auto_b = 1; din_b = 8'(i); in_valid_b = 1; ack_b = 4'b1111;
            @(posedge clk); #1;
        end
        @(negedge clk);
        din_b = 8'd9; clr_b = 1;
        @(posedge clk); #1;
        total++; if (q_b[23:16] !== 8'd9) begin bad++; $display("FAIL clr_slice2: got %0d exp 9", q_b[23:16]); end
        @(negedge clk);
        din_b = 8'd10; clr_b = 0;
        @(posedge clk); #1;
        total++; if (q_b[7:0] !== 8'd10) begin bad++; $display("FAIL clr_ptr0: got %0d exp 10", q_b[7:0]); end
        @(negedge clk);
        auto_b = 0; sel_b = 2'd3; din_b = 8'd11;
        @(posedge clk); #1;
        total++; if (q_b[31:24] !== 8'd11) begin bad++; $display("FAIL toggle_sel3: got %0d exp 11", q_b[31:24]); end
        @(negedge clk);
        auto_b = 1; din_b = 8'd12;
        @(posedge clk); #1;
        total++; if (q_b !== 32'h0B090C0A) begin bad++; $display("FAIL toggle_ptr_kept: got %h exp 0b090c0a", q_b); end
        @(negedge clk); idle_all();
    endtask

    task automatic test_err;
        do_reset();
        @(negedge clk);
        auto_c = 0; sel_c = 2'd3; din_c = 4'h5; in_valid_c = 1;
        #1;
        total++; if (in_ready_c !== 1'b1) begin bad++; $display("FAIL err_ready: got %b exp 1", in_ready_c); end
        @(posedge clk); #1;
        total++; if (err_c !== 1'b1)      begin bad++; $display("FAIL err_pulse: got %b exp 1", err_c); end
        total++; if (valid_c !== 3'b000)  begin bad++; $display("FAIL err_valid: got %b exp 000", valid_c); end
        total++; if (q_c !== 12'h000)     begin bad++; $display("FAIL err_q: got %h exp 000", q_c); end
        @(negedge clk);
        in_valid_c = 0;
        @(posedge clk); #1;
        total++; if (err_c !== 1'b0)      begin bad++; $display("FAIL err_one_cycle: got %b exp 0", err_c); end
        @(negedge clk);
        sel_c = 2'd2; in_valid_c = 1;
        @(posedge clk); #1;
        total++; if (err_c !== 1'b0)      begin bad++; $display("FAIL err_inrange: got %b exp 0", err_c); end
        total++; if (q_c !== 12'h500)     begin bad++; $display("FAIL err_inrange_q: got %h exp 500", q_c); end
        total++; if (valid_c !== 3'b100)  begin bad++; $display("FAIL err_inrange_valid: got %b exp 100", valid_c); end
        @(negedge clk); idle_all();
    endtask

    task automatic test_reset_mid;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            din_a = 1; sel_a = s[0]; in_valid_a = 1; ack_a = 2'b00;
            @(posedge clk); #1;
        end
        total++; if (valid_a !== 2'b11) begin bad++; $display("FAIL rmid_pre_valid: got %b exp 11", valid_a); end
        total++; if (q_a !== 2'b11)     begin bad++; $display("FAIL rmid_pre_q: got %b exp 11", q_a); end
        @(negedge clk);
        in_valid_a = 0;
        #1 rst = 1'b1;
        #1;
        total++; if (q_a !== 2'b00)      begin bad++; $display("FAIL rmid_q: got %b exp 00", q_a); end
        total++; if (valid_a !== 2'b00)  begin bad++; $display("FAIL rmid_valid: got %b exp 00", valid_a); end
        total++; if (valid_c !== 3'b000) begin bad++; $display("FAIL rmid_valid_c: got %b exp 000", valid_c); end
        total++; if (q_c !== 12'h000)    begin bad++; $display("FAIL rmid_q_c: got %h exp 000", q_c); end
        #1 rst = 1'b0;
        #1;
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b exp 1", in_ready_a); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        din_a = 0; sel_a = 0;
        din_b = '0; sel_b = '0;
        din_c = '0; sel_c = '0;
        idle_all();
        test_reset();
        test_select_n2();
        test_backpressure();
        test_ack();
        test_auto_scan();
        test_sync_clr();
        test_err();
        // Leave instance c holding valid=100 so the mid-run reset also clears it
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
